// File: rtl/sm_regdump_pkg.sv
// Shared definitions for the schoolMIPS debug-port register dumper.
package sm_regdump_pkg;

  // Default frame header byte.
  localparam logic [7:0] DEF_HDR_BYTE = 8'hA5;

  // Bytes emitted per register: address byte plus four data bytes.
  localparam int BYTES_PER_REG = 5;

  // Dumper states:
  //   S_IDLE  : waiting for start
  //   S_HDR   : header byte on the stream
  //   S_LATCH : one quiet cycle, capture regData for the current regAddr
  //   S_ADDR  : register address byte on the stream
  //   S_DATA  : four data bytes, MSB first
  //   S_SUM   : XOR checksum byte on the stream
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_LATCH = 3'd2,
    S_ADDR  = 3'd3,
    S_DATA  = 3'd4,
    S_SUM   = 3'd5
  } state_t;

  // Address byte as it appears on the stream.
  function automatic logic [7:0] addrByte(input logic [4:0] addr);
    return {3'b000, addr};
  endfunction

endpackage

// File: rtl/sm_regdump.sv
// Walks the CPU debug port over registers 0..NUM_REGS-1 and streams a framed
// snapshot (header, addr+data per register, XOR checksum) over valid/ready.
module sm_regdump
  import sm_regdump_pkg::*;
#(
  parameter int         NUM_REGS = 32,
  parameter logic [7:0] HDR_BYTE = DEF_HDR_BYTE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic        busy,
  output logic        done,
  output logic [7:0]  txData,
  output logic        txValid,
  input  logic        txReady
);

  localparam logic [4:0] LAST_ADDR = 5'(NUM_REGS - 1);

  state_t      state;
  logic [31:0] shreg;
  logic [7:0]  csum;
  logic [1:0]  bcnt;
  logic        hs;

  // Byte leaves the block on the clock edge where both sides agree.
  assign hs = txValid & txReady;

  // Sequencer: all stream outputs are registered, so txReady never reaches
  // txValid combinationally and a stalled byte simply holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      regAddr <= 5'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      txValid <= 1'b0;
      txData  <= 8'h00;
      csum    <= 8'h00;
      bcnt    <= 2'd0;
      shreg   <= 32'h0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_HDR;
            regAddr <= 5'd0;
            csum    <= 8'h00;
            busy    <= 1'b1;
            txValid <= 1'b1;
            txData  <= HDR_BYTE;
          end
        end

        S_HDR: begin
          if (hs) begin
            state   <= S_LATCH;
            txValid <= 1'b0;
          end
        end

        // regAddr has been stable for this whole cycle, so regData is settled.
        S_LATCH: begin
          shreg   <= regData;
          state   <= S_ADDR;
          txValid <= 1'b1;
          txData  <= addrByte(regAddr);
        end

        S_ADDR: begin
          if (hs) begin
            csum   <= csum ^ txData;
            bcnt   <= 2'd0;
            state  <= S_DATA;
            txData <= shreg[31:24];
          end
        end

        // txData always mirrors shreg[31:24]; shifting exposes the next byte.
        S_DATA: begin
          if (hs) begin
            csum  <= csum ^ txData;
            shreg <= {shreg[23:0], 8'h00};
            bcnt  <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              if (regAddr == LAST_ADDR) begin
                state  <= S_SUM;
                txData <= csum ^ txData;
              end else begin
                regAddr <= regAddr + 5'd1;
                state   <= S_LATCH;
                txValid <= 1'b0;
              end
            end else begin
              txData <= shreg[23:16];
            end
          end
        end

        S_SUM: begin
          if (hs) begin
            state   <= S_IDLE;
            txValid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end

        default: begin
          state   <= S_IDLE;
          txValid <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // A stalled byte must stay put until it is taken.
  always @(posedge clk) begin
    assert property (disable iff (rst)
      (txValid && !txReady) |=> (txValid && txData == $past(txData)));
  end

  // The address never runs past the last dumped register.
  always @(posedge clk) begin
    assert property (disable iff (rst) regAddr <= LAST_ADDR);
  end

  // done marks the end of a frame, so the block cannot still be busy.
  always @(posedge clk) begin
    assert property (disable iff (rst) done |-> !busy);
  end

endmodule

// File: tb/tb_sm_regdump.sv
// Self-checking bench for sm_regdump: one dumper with a single register and
// one with the full 32-register file, checked against a frame model.
module tb_sm_regdump;

  logic        clk;
  logic        rstDrv, startDrv, readyDrv, sel;

  logic [4:0]  regAddr1, regAddr32;
  logic [31:0] regData1, regData32;
  logic        busy1, busy32, done1, done32, txValid1, txValid32;
  logic [7:0]  txData1, txData32;

  logic        mValid, mBusy, mDone;
  logic [7:0]  mData;
  logic [4:0]  mAddr;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    bit         use32;
    int         readyPct;
    bit         repulse;
    int         expLen;
    logic [7:0] expSum;
    int         expDone;
  } vec_t;

  vec_t vecs[6];

  // CPU debug-port contents seen by each instance.
  function automatic logic [31:0] regModel(input bit use32, input int i);
    if (use32) return 32'(i) * 32'h01010101;
    return 32'hDEADBE00 | 32'(i);
  endfunction

  assign regData1  = regModel(1'b0, int'(regAddr1));
  assign regData32 = regModel(1'b1, int'(regAddr32));

  sm_regdump #(.NUM_REGS(1)) dut1 (
    .clk(clk), .rst(rstDrv), .start(startDrv & ~sel),
    .regAddr(regAddr1), .regData(regData1),
    .busy(busy1), .done(done1),
    .txData(txData1), .txValid(txValid1), .txReady(readyDrv)
  );

  sm_regdump #(.NUM_REGS(32)) dut32 (
    .clk(clk), .rst(rstDrv), .start(startDrv & sel),
    .regAddr(regAddr32), .regData(regData32),
    .busy(busy32), .done(done32),
    .txData(txData32), .txValid(txValid32), .txReady(readyDrv)
  );

  assign mValid = sel ? txValid32 : txValid1;
  assign mBusy  = sel ? busy32    : busy1;
  assign mDone  = sel ? done32    : done1;
  assign mData  = sel ? txData32  : txData1;
  assign mAddr  = sel ? regAddr32 : regAddr1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drive one complete frame and compare it with the frame built from the rules.
  task automatic runFrame(input vec_t v);
    logic [7:0]  expQ[$];
    logic [7:0]  gotQ[$];
    logic [31:0] rv;
    logic [7:0]  cs;
    logic [7:0]  prevData;
    bit          prevStall;
    int          n, doneCyc, maxAddr, cmpLen;

    n  = v.use32 ? 32 : 1;
    cs = 8'h00;
    expQ.push_back(8'hA5);
    for (int i = 0; i < n; i++) begin
      rv = regModel(v.use32, i);
      expQ.push_back(8'(i));
      cs ^= 8'(i);
      for (int b = 3; b >= 0; b--) begin
        expQ.push_back(rv[b*8 +: 8]);
        cs ^= rv[b*8 +: 8];
      end
    end
    expQ.push_back(cs);

    sel      = v.use32;
    readyDrv = 1'b0;
    @(negedge clk);
    startDrv  = 1'b1;
    doneCyc   = -1;
    prevStall = 1'b0;
    prevData  = 8'h00;
    maxAddr   = 0;
    for (int cyc = 1; cyc <= 4000; cyc++) begin
      @(negedge clk);
      startDrv = v.repulse && (cyc == 5);
      if (mDone) begin
        doneCyc = cyc;
        check("busy low with done", 32'(mBusy), 32'd0);
        break;
      end
      check("busy during frame", 32'(mBusy), 32'd1);
      if (prevStall) begin
        check("stall valid held", 32'(mValid), 32'd1);
        check("stall data held", 32'(mData), 32'(prevData));
      end
      if (int'(mAddr) > maxAddr) maxAddr = int'(mAddr);
      readyDrv = ($urandom_range(99) < 32'(v.readyPct));
      if (mValid && readyDrv) gotQ.push_back(mData);
      prevStall = mValid && !readyDrv;
      prevData  = mData;
    end
    startDrv = 1'b0;

    check("frame done seen", 32'(doneCyc >= 0), 32'd1);
    check("frame length", 32'(gotQ.size()), 32'(v.expLen));
    check("model length", 32'(gotQ.size()), 32'(expQ.size()));
    cmpLen = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
    for (int k = 0; k < cmpLen; k++) begin
      if (gotQ[k] !== expQ[k]) begin
        tests++;
        failed++;
        $display("FAIL byte %0d: got %h expected %h", k, gotQ[k], expQ[k]);
      end else begin
        tests++;
      end
    end
    if (gotQ.size() > 0) check("checksum byte", 32'(gotQ[gotQ.size()-1]), 32'(v.expSum));
    if (v.expDone >= 0) check("done cycle", 32'(doneCyc), 32'(v.expDone));
    if (v.use32) check("regAddr sweep top", 32'(maxAddr), 32'd31);

    @(negedge clk);
    check("done single pulse", 32'(mDone), 32'd0);
    check("no restart after frame", 32'(mValid), 32'd0);
  endtask

  initial begin
    int firstDone, secondDone, hsCnt;
    bit sawActivity;

    vecs[0] = '{use32: 1'b0, readyPct: 100, repulse: 1'b0, expLen: 7,   expSum: 8'hCD, expDone: 9};
    vecs[1] = '{use32: 1'b0, readyPct: 50,  repulse: 1'b0, expLen: 7,   expSum: 8'hCD, expDone: -1};
    vecs[2] = '{use32: 1'b0, readyPct: 50,  repulse: 1'b1, expLen: 7,   expSum: 8'hCD, expDone: -1};
    vecs[3] = '{use32: 1'b1, readyPct: 100, repulse: 1'b0, expLen: 162, expSum: 8'h00, expDone: 195};
    vecs[4] = '{use32: 1'b1, readyPct: 60,  repulse: 1'b1, expLen: 162, expSum: 8'h00, expDone: -1};
    vecs[5] = '{use32: 1'b1, readyPct: 100, repulse: 1'b1, expLen: 162, expSum: 8'h00, expDone: 195};

    rstDrv   = 1'b1;
    startDrv = 1'b0;
    readyDrv = 1'b0;
    sel      = 1'b0;

    // Reset state of both instances.
    repeat (2) @(negedge clk);
    check("rst txValid1", 32'(txValid1), 32'd0);
    check("rst txData1", 32'(txData1), 32'd0);
    check("rst busy1", 32'(busy1), 32'd0);
    check("rst done1", 32'(done1), 32'd0);
    check("rst regAddr1", 32'(regAddr1), 32'd0);
    check("rst txValid32", 32'(txValid32), 32'd0);
    check("rst txData32", 32'(txData32), 32'd0);
    check("rst busy32", 32'(busy32), 32'd0);
    check("rst done32", 32'(done32), 32'd0);
    check("rst regAddr32", 32'(regAddr32), 32'd0);
    rstDrv = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 6; t++) runFrame(vecs[t]);

    // start held high: back-to-back frames with one IDLE cycle between.
    sel        = 1'b0;
    readyDrv   = 1'b1;
    firstDone  = -1;
    secondDone = -1;
    @(negedge clk);
    startDrv = 1'b1;
    for (int cyc = 1; cyc <= 40 && secondDone < 0; cyc++) begin
      @(negedge clk);
      if (firstDone < 0) begin
        if (mDone) begin
          firstDone = cyc;
          check("held idle busy", 32'(mBusy), 32'd0);
          check("held idle valid", 32'(mValid), 32'd0);
        end
      end else if (cyc == firstDone + 1) begin
        check("held restart valid", 32'(mValid), 32'd1);
        check("held restart hdr", 32'(mData), 32'hA5);
        check("held restart busy", 32'(mBusy), 32'd1);
        startDrv = 1'b0;
      end else if (mDone) begin
        secondDone = cyc;
      end
    end
    startDrv = 1'b0;
    check("held first done", 32'(firstDone), 32'd9);
    check("held second done", 32'(secondDone), 32'd18);
    repeat (2) @(negedge clk);

    // Reset after the third handshake aborts the frame without done.
    sel      = 1'b0;
    readyDrv = 1'b1;
    hsCnt    = 0;
    @(negedge clk);
    startDrv = 1'b1;
    for (int c = 0; c < 20 && hsCnt < 3; c++) begin
      @(negedge clk);
      startDrv = 1'b0;
      if (mValid && readyDrv) hsCnt++;
    end
    check("abort handshakes", 32'(hsCnt), 32'd3);
    @(negedge clk);
    rstDrv = 1'b1;
    @(negedge clk);
    rstDrv = 1'b0;
    check("abort txValid", 32'(mValid), 32'd0);
    check("abort busy", 32'(mBusy), 32'd0);
    sawActivity = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (mDone || mValid || mBusy) sawActivity = 1'b1;
    end
    check("abort no done", 32'(sawActivity), 32'd0);
    runFrame(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
